// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter in front of a single shared slave bus.
// Master 0 is the instruction fetcher, master 1 the load/store unit.
// Ownership is held for as long as the granted master keeps cyc high.
// Simultaneous requests from IDLE are resolved round-robin.
// A wait counter aborts a transfer that the slave never acknowledges.
//
// Handshake: a master's request is valid while its cyc is high. The cycle is
// complete when the slave returns ack or err while o_s_cyc is high, or when
// the arbiter raises err itself on timeout. Ack/err reach only the owner.
// Read data is broadcast to both masters and is meaningful only with ack.
module wb_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        i_clk,
    input  logic        i_reset,

    // master 0 (instruction fetch)
    input  logic        i_m0_cyc,
    input  logic [3:0]  i_m0_stb,
    input  logic        i_m0_we,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_dat,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_err,

    // master 1 (load/store)
    input  logic        i_m1_cyc,
    input  logic [3:0]  i_m1_stb,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_dat,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,

    // shared slave bus
    output logic        o_s_cyc,
    output logic [3:0]  o_s_stb,
    output logic        o_s_we,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_dat,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_ack,
    input  logic        i_s_err,

    // status
    output logic [1:0]  o_grant,
    output logic        o_timeout,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last;        // index of the master granted most recently
    logic        last_nxt;
    logic [7:0]  wait_cnt;    // granted cycles spent waiting for ack/err
    logic [7:0]  wait_cnt_nxt;

    // request of the current owner (all zero while idle)
    logic        own_cyc;
    logic [3:0]  own_stb;
    logic        own_we;
    logic [31:0] own_addr;
    logic [31:0] own_dat;

    logic        tmo;         // abort the owner's transfer this cycle
    logic        bus_cyc;     // cyc actually presented to the slave
    logic        ack_g;       // slave ack qualified by an active bus cycle
    logic        err_g;       // slave err qualified, or a timeout abort

    // Select the owning master's request; nothing is routed while idle.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 4'b0;
        own_we   = 1'b0;
        own_addr = 32'b0;
        own_dat  = 32'b0;
        case (state)
            GNT0: begin
                own_cyc  = i_m0_cyc;
                own_stb  = i_m0_stb;
                own_we   = i_m0_we;
                own_addr = i_m0_addr;
                own_dat  = i_m0_dat;
            end
            GNT1: begin
                own_cyc  = i_m1_cyc;
                own_stb  = i_m1_stb;
                own_we   = i_m1_we;
                own_addr = i_m1_addr;
                own_dat  = i_m1_dat;
            end
            default: ;
        endcase
    end

    // A slave response in the timeout cycle wins, so timeout needs a silent
    // slave. It is computed from the raw slave inputs to avoid a loop
    // through o_s_cyc.
    assign tmo     = own_cyc & ~i_s_ack & ~i_s_err & (wait_cnt == TIMEOUT);
    assign bus_cyc = own_cyc & ~tmo;
    assign ack_g   = bus_cyc & i_s_ack;
    assign err_g   = (bus_cyc & i_s_err) | tmo;

    // Drive the slave bus; cyc and stb drop in the abort cycle.
    always_comb begin
        o_s_cyc  = bus_cyc;
        o_s_stb  = tmo ? 4'b0 : own_stb;
        o_s_we   = own_we;
        o_s_addr = own_addr;
        o_s_dat  = own_dat;
    end

    // Route responses only to the owner so the two masters never both see one.
    always_comb begin
        o_m0_ack  = (state == GNT0) & ack_g;
        o_m0_err  = (state == GNT0) & err_g;
        o_m1_ack  = (state == GNT1) & ack_g;
        o_m1_err  = (state == GNT1) & err_g;
        o_m0_dat  = i_s_dat;
        o_m1_dat  = i_s_dat;
        o_grant   = {state == GNT1, state == GNT0};
        o_timeout = tmo;
    end

    assign o_dbg_state = state;

    // Next ownership, round-robin memory and wait counter.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        wait_cnt_nxt = wait_cnt;

        case (state)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_nxt = last ? GNT0 : GNT1;
                end else if (i_m0_cyc) begin
                    state_nxt = GNT0;
                end else if (i_m1_cyc) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (tmo) begin
                    state_nxt = IDLE;
                end else if (!i_m0_cyc) begin
                    // hand straight over to a waiting master, no idle gap
                    state_nxt = i_m1_cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (tmo) begin
                    state_nxt = IDLE;
                end else if (!i_m1_cyc) begin
                    state_nxt = i_m0_cyc ? GNT0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if ((state_nxt == GNT0) && (state != GNT0)) begin
            last_nxt = 1'b0;
        end else if ((state_nxt == GNT1) && (state != GNT1)) begin
            last_nxt = 1'b1;
        end

        if ((state == IDLE) || (state_nxt != state) || ack_g || err_g) begin
            wait_cnt_nxt = 8'd0;
        end else if (own_cyc) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
        end
    end

    // State register; reset leaves master 1 as last so master 0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a directed vector table, hand-written timeout and
// reset sequences, then randomized traffic against a reference model.
module tb_wb_arbiter;

    localparam logic [7:0] TMO = 8'd4;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_m0_cyc, i_m0_we, i_m1_cyc, i_m1_we;
    logic [3:0]  i_m0_stb, i_m1_stb;
    logic [31:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat;
    logic [31:0] o_m0_dat, o_m1_dat;
    logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
    logic        o_s_cyc, o_s_we;
    logic [3:0]  o_s_stb;
    logic [31:0] o_s_addr, o_s_dat, i_s_dat;
    logic        i_s_ack, i_s_err;
    logic [1:0]  o_grant;
    logic        o_timeout;
    logic [1:0]  o_dbg_state;

    wb_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
        .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat),
        .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
        .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
        .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat),
        .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
        .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
        .o_s_addr(o_s_addr), .o_s_dat(o_s_dat), .i_s_dat(i_s_dat),
        .i_s_ack(i_s_ack), .i_s_err(i_s_err),
        .o_grant(o_grant), .o_timeout(o_timeout), .o_dbg_state(o_dbg_state)
    );

    // clock
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    // reference model: who owns the bus (0 none, 1 master 0, 2 master 1),
    // which master index was granted last, and cycles waited so far
    int mdl_own;
    int mdl_last;
    int mdl_wait;
    logic mdl_own_cyc;

    logic [1:0]  e_grant;
    logic        e_tmo, e_scyc, e_we;
    logic [3:0]  e_stb;
    logic [31:0] e_addr, e_dat;
    logic        e_a0, e_e0, e_a1, e_e1;

    typedef struct packed {
        logic [4:0] in;   // rst, c0, c1, ack, err
        logic [7:0] ex;   // grant[1:0], s_cyc, m0_ack, m0_err, m1_ack, m1_err, timeout
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic row(input logic [4:0] in, input logic [7:0] ex);
        vec_t v;
        v.in = in;
        v.ex = ex;
        tbl.push_back(v);
    endtask

    // driver: fixed master payloads, slave returns DEADBEEF
    task automatic drive(input logic rst, c0, c1, ack, err);
        i_reset   = rst;
        i_m0_cyc  = c0;
        i_m1_cyc  = c1;
        i_s_ack   = ack;
        i_s_err   = err;
        i_m0_stb  = 4'hf;
        i_m0_we   = 1'b0;
        i_m0_addr = 32'h0000_0100;
        i_m0_dat  = 32'h0;
        i_m1_stb  = 4'h3;
        i_m1_we   = 1'b1;
        i_m1_addr = 32'h0000_0200;
        i_m1_dat  = 32'h1234_5678;
        i_s_dat   = 32'hDEAD_BEEF;
    endtask

    // expected outputs this cycle, from the arbitration rules
    task automatic model_eval();
        if (!i_reset) begin
            mdl_own  = 0;
            mdl_last = 1;
            mdl_wait = 0;
        end
        mdl_own_cyc = 1'b0;
        e_stb = 4'h0; e_we = 1'b0; e_addr = 32'h0; e_dat = 32'h0;
        if (mdl_own == 1) begin
            mdl_own_cyc = i_m0_cyc;
            e_stb = i_m0_stb; e_we = i_m0_we; e_addr = i_m0_addr; e_dat = i_m0_dat;
        end else if (mdl_own == 2) begin
            mdl_own_cyc = i_m1_cyc;
            e_stb = i_m1_stb; e_we = i_m1_we; e_addr = i_m1_addr; e_dat = i_m1_dat;
        end
        e_tmo  = mdl_own_cyc && !i_s_ack && !i_s_err && (mdl_wait == int'(TMO));
        e_scyc = mdl_own_cyc && !e_tmo;
        if (e_tmo) e_stb = 4'h0;
        e_grant = (mdl_own == 1) ? 2'b01 : (mdl_own == 2) ? 2'b10 : 2'b00;
        e_a0 = (mdl_own == 1) && e_scyc && i_s_ack;
        e_a1 = (mdl_own == 2) && e_scyc && i_s_ack;
        e_e0 = (mdl_own == 1) && ((e_scyc && i_s_err) || e_tmo);
        e_e1 = (mdl_own == 2) && ((e_scyc && i_s_err) || e_tmo);
    endtask

    task automatic model_advance();
        int nxt;
        if (!i_reset) return;
        if (mdl_own == 0) begin
            if (i_m0_cyc && i_m1_cyc) nxt = (mdl_last == 0) ? 2 : 1;
            else if (i_m0_cyc)        nxt = 1;
            else if (i_m1_cyc)        nxt = 2;
            else                      nxt = 0;
        end else if (e_tmo) begin
            nxt = 0;
        end else if (!mdl_own_cyc) begin
            if (mdl_own == 1) nxt = i_m1_cyc ? 2 : 0;
            else              nxt = i_m0_cyc ? 1 : 0;
        end else begin
            nxt = mdl_own;
        end
        if (nxt != mdl_own || mdl_own == 0 || e_a0 || e_a1 || e_e0 || e_e1) mdl_wait = 0;
        else mdl_wait++;
        if (nxt != 0 && nxt != mdl_own) mdl_last = nxt - 1;
        mdl_own = nxt;
    endtask

    // settle, compare against the model, run the read-data scoreboard
    task automatic cyc_chk(input string tag);
        logic [31:0] got_d;
        #2;
        model_eval();
        chk({tag, "_ctrl"},
            64'({o_grant, o_timeout, o_s_cyc, o_s_stb, o_s_we, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}),
            64'({e_grant, e_tmo, e_scyc, e_stb, e_we, e_a0, e_e0, e_a1, e_e1}));
        chk({tag, "_addr"}, 64'(o_s_addr), 64'(e_addr));
        chk({tag, "_wdat"}, 64'(o_s_dat), 64'(e_dat));
        chk({tag, "_excl"}, 64'((o_m0_ack | o_m0_err) & (o_m1_ack | o_m1_err)), 64'd0);
        if (e_a0 || e_a1) exp_q.push_back(i_s_dat);
        if (o_m0_ack || o_m1_ack) begin
            got_d = o_m0_ack ? o_m0_dat : o_m1_dat;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s_sb: ack with data %0h but none expected", tag, got_d);
            end else begin
                chk({tag, "_sb_rdata"}, 64'(got_d), 64'(exp_q.pop_front()));
            end
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic c0, c1;
        logic [7:0] got_v;
        logic [31:0] want_addr;

        //       rst c0 c1 ack err    grant scyc a0 e0 a1 e1 tmo
        row(5'b0_0_0_0_0, 8'b00_0_0_0_0_0_0);   // in reset
        row(5'b1_1_0_0_0, 8'b00_0_0_0_0_0_0);   // m0 alone requests
        row(5'b1_1_0_0_0, 8'b01_1_0_0_0_0_0);   // granted one cycle later
        row(5'b1_1_0_0_0, 8'b01_1_0_0_0_0_0);
        row(5'b1_1_0_1_0, 8'b01_1_1_0_0_0_0);   // ack two cycles after grant
        row(5'b1_0_0_0_0, 8'b01_0_0_0_0_0_0);   // release
        row(5'b1_0_0_0_0, 8'b00_0_0_0_0_0_0);
        row(5'b0_0_0_0_0, 8'b00_0_0_0_0_0_0);   // reset again
        row(5'b1_1_1_0_0, 8'b00_0_0_0_0_0_0);   // both request together
        row(5'b1_1_1_0_0, 8'b01_1_0_0_0_0_0);   // m0 wins first tie
        row(5'b1_1_1_1_0, 8'b01_1_1_0_0_0_0);
        row(5'b1_0_1_0_0, 8'b01_0_0_0_0_0_0);   // m0 drops, m1 waits
        row(5'b1_0_1_0_0, 8'b10_1_0_0_0_0_0);   // handover with no idle cycle
        row(5'b1_1_1_1_0, 8'b10_1_0_0_1_0_0);
        row(5'b1_1_0_0_0, 8'b10_0_0_0_0_0_0);   // m1 drops after ack
        row(5'b1_1_1_0_0, 8'b01_1_0_0_0_0_0);
        row(5'b1_1_1_1_0, 8'b01_1_1_0_0_0_0);
        row(5'b1_0_1_0_0, 8'b01_0_0_0_0_0_0);
        row(5'b1_1_1_0_0, 8'b10_1_0_0_0_0_0);
        row(5'b1_1_1_1_0, 8'b10_1_0_0_1_0_0);
        row(5'b1_1_0_0_0, 8'b10_0_0_0_0_0_0);
        row(5'b1_1_1_0_0, 8'b01_1_0_0_0_0_0);
        row(5'b1_0_0_0_0, 8'b01_0_0_0_0_0_0);
        row(5'b1_0_0_0_0, 8'b00_0_0_0_0_0_0);
        row(5'b1_0_1_0_0, 8'b00_0_0_0_0_0_0);   // m1 alone
        row(5'b1_0_1_0_1, 8'b10_1_0_0_0_1_0);   // slave err routed to m1 only
        row(5'b1_0_0_0_0, 8'b10_0_0_0_0_0_0);
        row(5'b1_0_0_0_0, 8'b00_0_0_0_0_0_0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            cyc_chk("tbl");
            got_v = {o_grant, o_s_cyc, o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_timeout};
            chk($sformatf("tbl_row%0d", i), 64'(got_v), 64'(tbl[i].ex));
            want_addr = (tbl[i].ex[7:6] == 2'b01) ? 32'h100 :
                        (tbl[i].ex[7:6] == 2'b10) ? 32'h200 : 32'h0;
            chk($sformatf("tbl_addr%0d", i), 64'(o_s_addr), 64'(want_addr));
            if (tbl[i].ex[4]) chk("tbl_m0_rdata", 64'(o_m0_dat), 64'h0000_0000_DEAD_BEEF);
            tick();
        end

        // m1 alone, slave never answers: abort on the fifth granted cycle
        drive(1, 0, 1, 0, 0); cyc_chk("to_req"); chk("to_req_grant", 64'(o_grant), 64'd0); tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 1, 0, 0); cyc_chk("to_wait");
            chk("to_wait_sig", 64'({o_grant, o_m1_err, o_timeout, o_s_cyc}), 64'({2'b10, 3'b001}));
            tick();
        end
        drive(1, 0, 1, 0, 0); cyc_chk("to_abort");
        chk("to_abort_sig", 64'({o_grant, o_m1_err, o_m0_err, o_timeout, o_s_cyc, o_s_stb}),
            64'({2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0}));
        tick();
        drive(1, 0, 1, 0, 0); cyc_chk("to_after"); chk("to_after_grant", 64'({o_grant, o_timeout}), 64'd0); tick();
        drive(1, 0, 1, 0, 0); cyc_chk("to_regrant"); chk("to_regrant_grant", 64'(o_grant), 64'(2'b10)); tick();
        drive(1, 0, 0, 0, 0); cyc_chk("to_rel"); tick();

        // ack lands exactly on the timeout cycle: ack wins
        drive(1, 1, 0, 0, 0); cyc_chk("ak_req"); tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 1, 0, 0, 0); cyc_chk("ak_wait"); tick();
        end
        drive(1, 1, 0, 1, 0); cyc_chk("ak_hit");
        chk("ak_hit_sig", 64'({o_m0_ack, o_m0_err, o_timeout, o_s_cyc}), 64'(4'b1001));
        chk("ak_hit_rdata", 64'(o_m0_dat), 64'h0000_0000_DEAD_BEEF);
        tick();
        drive(1, 0, 0, 0, 0); cyc_chk("ak_rel"); tick();
        drive(1, 0, 0, 0, 0); cyc_chk("ak_idle"); chk("ak_idle_grant", 64'(o_grant), 64'd0); tick();

        // reset asserted in the middle of a granted transfer
        drive(1, 1, 0, 0, 0); cyc_chk("rs_req"); tick();
        drive(1, 1, 0, 0, 0); cyc_chk("rs_gnt"); chk("rs_gnt_grant", 64'(o_grant), 64'(2'b01)); tick();
        drive(0, 1, 0, 1, 0); cyc_chk("rs_hit");
        chk("rs_hit_sig", 64'({o_grant, o_s_cyc, o_s_stb, o_m0_ack, o_m0_err, o_timeout}), 64'd0);
        tick();
        drive(1, 1, 0, 0, 0); cyc_chk("rs_idle"); chk("rs_idle_grant", 64'(o_grant), 64'd0); tick();
        drive(1, 1, 0, 0, 0); cyc_chk("rs_again"); chk("rs_again_grant", 64'(o_grant), 64'(2'b01)); tick();
        drive(1, 0, 0, 0, 0); cyc_chk("rs_rel"); tick();

        // randomized traffic; odd blocks use a slow slave to provoke timeouts
        c0 = 1'b0;
        c1 = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) c0 = ~c0;
            if ($urandom_range(0, 3) == 0) c1 = ~c1;
            drive(($urandom_range(0, 199) != 0), c0, c1,
                  ((n / 500) % 2 == 1) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 19) == 0));
            i_m0_stb  = 4'($urandom_range(0, 15));
            i_m1_stb  = 4'($urandom_range(0, 15));
            i_m0_we   = 1'($urandom_range(0, 1));
            i_m1_we   = 1'($urandom_range(0, 1));
            i_m0_addr = $urandom;
            i_m1_addr = $urandom;
            i_m0_dat  = $urandom;
            i_m1_dat  = $urandom;
            i_s_dat   = $urandom;
            cyc_chk("rnd");
            tick();
        end

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255: max cycles a granted master may hold cyc without ack/err.
REQ-002 SHALL have ports i_clk input 1 (sole clock) and i_reset input 1 (asynchronous, active-low reset).
REQ-003 SHALL have ports i_m0_cyc input 1, i_m0_stb input 4, i_m0_we input 1, i_m0_addr input 32, i_m0_dat input 32: master 0 (instruction fetcher) request.
REQ-004 SHALL have ports o_m0_dat output 32, o_m0_ack output 1, o_m0_err output 1: master 0 response.
REQ-005 SHALL have ports i_m1_cyc, i_m1_stb[3:0], i_m1_we, i_m1_addr[31:0], i_m1_dat[31:0] inputs and o_m1_dat[31:0], o_m1_ack, o_m1_err outputs: master 1 (load/store) with identical semantics.
REQ-006 SHALL have ports o_s_cyc output 1, o_s_stb output 4, o_s_we output 1, o_s_addr output 32, o_s_dat output 32, i_s_dat input 32, i_s_ack input 1, i_s_err input 1: shared slave bus.
REQ-007 SHALL have ports o_grant output 2 (one-hot owner, 00 when idle) and o_timeout output 1 (one-cycle pulse on timeout abort).

Function
REQ-008 SHALL implement registered FSM with states IDLE, GNT0, GNT1; o_grant = 01 in GNT0, 10 in GNT1, 00 in IDLE.
REQ-009 SHALL, in IDLE, go to GNT0 if only m0_cyc, GNT1 if only m1_cyc, and with both requesting grant the master not in register last (round-robin).
REQ-010 SHALL update last to the granted index on every entry into GNT0/GNT1.
REQ-011 SHALL impose one cycle arbitration latency: request seen in IDLE at cycle N, slave bus driven from cycle N+1.
REQ-012 SHALL, in GNTx, combinationally route mx cyc/stb/we/addr/dat to o_s_*; in IDLE drive o_s_cyc=0, o_s_stb=0, o_s_we=0, o_s_addr=0, o_s_dat=0.
REQ-013 SHALL route i_s_ack, i_s_err only to the granted master, gated by o_s_cyc; non-granted master sees ack=0, err=0.
REQ-014 SHALL drive o_m0_dat and o_m1_dat both from i_s_dat unconditionally (validity qualified by ack).
REQ-015 SHALL, in GNTx with mx_cyc=0, release: next state GNTy if my_cyc=1, else IDLE; no idle gap when handing over.
REQ-016 SHALL keep GNTx while mx_cyc=1, regardless of the other master's request (no preemption).
REQ-017 SHALL keep an 8-bit wait counter: cleared in IDLE, on any state change, and on gated ack/err; incremented each GNTx cycle with mx_cyc=1 and no ack/err.
REQ-018 SHALL, when counter equals TIMEOUT with mx_cyc=1 and no ack/err: assert o_mx_err and o_timeout that cycle, force o_s_cyc=0 and o_s_stb=0 that cycle, and go to IDLE next cycle.
REQ-019 SHALL, when a slave ack and the timeout condition coincide, treat the ack as winning: ack passed through, no err, no o_timeout.
REQ-020 SHALL never assert o_m0_ack/err and o_m1_ack/err in the same cycle.
REQ-021 SHALL, after timeout abort to IDLE, re-arbitrate normally (aborting master may be re-granted if it still requests and wins round-robin).
REQ-022 SHALL be fully synchronous to i_clk apart from the reset.

Reset
REQ-023 SHALL, while i_reset=0, asynchronously force state IDLE, last=1 (so m0 wins the first tie), counter=0.
REQ-024 SHALL therefore output during reset o_grant=00, o_timeout=0, all o_s_* = 0, all master ack/err = 0.
REQ-025 SHALL abandon any in-flight transfer on reset assertion mid-cycle with no ack/err delivered; after release resume from IDLE.

Verification
REQ-026 SHALL cover: m0 alone reads addr 0x100, slave acks 2 cycles after grant with 0xDEADBEEF -> o_grant=01 one cycle after m0_cyc, o_m0_ack with dat 0xDEADBEEF, o_m1_ack stays 0.
REQ-027 SHALL cover: m0 and m1 assert cyc same cycle after reset -> GNT0 first; m0 drops cyc, m1 still requesting -> GNT1 next cycle with no IDLE cycle.
REQ-028 SHALL cover: both requesting continuously, each dropping cyc one cycle after ack -> grants alternate 01,10,01,10.
REQ-029 SHALL cover: m1 granted, slave never acks, TIMEOUT=4 -> o_m1_err and o_timeout pulse on 5th granted cycle, o_s_cyc=0 that cycle, o_grant=00 next cycle.
REQ-030 SHALL cover: ack arriving exactly on the timeout cycle -> ack delivered, o_timeout=0; plus i_reset=0 mid-transfer -> o_grant=00 and o_s_cyc=0 immediately, no ack.
